// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing with memory handshake and sticky trap.
// Define MULDIV_EN to route R-type funct7=0000001 to an external multiply/divide unit (adds md_start/md_done).
module multicycle_controller #(
    parameter int ALU_CTRL_W  = 4,
    parameter int IMM_SRC_W   = 3,
    parameter int MEM_TIMEOUT = 0
) (
`ifdef MULDIV_EN
    output logic                  md_start,
    input  logic                  md_done,
`endif
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [IMM_SRC_W-1:0]  imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  trap,
    output logic [1:0]            trap_cause
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [4:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR,
        S_JALWB, S_LUI, S_AUIPC, S_MULDIV, S_TRAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_state;
    logic             timeout;
    logic             taken;
    logic             br_legal;
    logic [3:0]       alu_dec;
    logic [3:0]       alu_code;
    logic [2:0]       imm_code;

    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout   = (MEM_TIMEOUT != 0) && mem_state && !mem_ready &&
                       (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign br_legal  = (funct3[2:1] != 2'b01);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    // op[5] separates R-type (0110011) from OP-IMM (0010011); only R-type may select SUB.
    always_comb begin
        alu_dec = 4'h0;
        case (funct3)
            3'b000:  alu_dec = (op[5] && funct7[5]) ? 4'h1 : 4'h0;
            3'b001:  alu_dec = 4'h7;
            3'b010:  alu_dec = 4'h5;
            3'b011:  alu_dec = 4'h6;
            3'b100:  alu_dec = 4'h4;
            3'b101:  alu_dec = funct7[5] ? 4'h9 : 4'h8;
            3'b110:  alu_dec = 4'h3;
            default: alu_dec = 4'h2;
        endcase
    end

    always_comb begin
        imm_code = 3'b000;
        case (op)
            7'b0100011:             imm_code = 3'b001;
            7'b1100011:             imm_code = 3'b010;
            7'b1101111:             imm_code = 3'b011;
            7'b0110111, 7'b0010111: imm_code = 3'b100;
            default:                imm_code = 3'b000;
        endcase
    end

    assign imm_src     = IMM_SRC_W'(imm_code);
    assign alu_control = ALU_CTRL_W'(alu_code);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
`ifdef MULDIV_EN
            md_start   <= 1'b0;
`endif
        end else begin
`ifdef MULDIV_EN
            md_start <= 1'b0;
`endif
            if (mem_state && !mem_ready && !timeout) begin
                if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        7'b0000011, 7'b0100011: state <= S_MEMADR;
                        7'b0110011: begin
                            if (funct7 == 7'b0000001) begin
`ifdef MULDIV_EN
                                state    <= S_MULDIV;
                                md_start <= 1'b1;
`else
                                state      <= S_TRAP;
                                trap       <= 1'b1;
                                trap_cause <= 2'b01;
`endif
                            end else begin
                                state <= S_EXEC_R;
                            end
                        end
                        7'b0010011: state <= S_EXEC_I;
                        7'b1100011: state <= S_BRANCH;
                        7'b1101111: state <= S_JAL;
                        7'b1100111: begin
                            if (funct3 == 3'b000) begin
                                state <= S_JALR;
                            end else begin
                                state      <= S_TRAP;
                                trap       <= 1'b1;
                                trap_cause <= 2'b01;
                            end
                        end
                        7'b0110111: state <= S_LUI;
                        7'b0010111: state <= S_AUIPC;
                        default: begin
                            state      <= S_TRAP;
                            trap       <= 1'b1;
                            trap_cause <= 2'b01;
                        end
                    endcase
                end
                S_MEMADR: state <= op[5] ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:  state <= S_FETCH;
                S_MEMWR:  if (mem_ready) state <= S_FETCH;
                S_EXEC_R, S_EXEC_I, S_JAL, S_LUI, S_AUIPC: state <= S_ALUWB;
                S_ALUWB:  state <= S_FETCH;
                S_BRANCH: begin
                    if (br_legal) begin
                        state <= S_FETCH;
                    end else begin
                        state      <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'b01;
                    end
                end
                S_JALR:   state <= S_JALWB;
                S_JALWB:  state <= S_ALUWB;
`ifdef MULDIV_EN
                S_MULDIV: if (md_done) state <= S_FETCH;
`endif
                S_TRAP:   state <= S_TRAP;
                default:  state <= S_FETCH;
            endcase

            // A ready arriving on the limit cycle keeps the transfer; only a miss traps.
            if (timeout) begin
                state      <= S_TRAP;
                trap       <= 1'b1;
                trap_cause <= 2'b10;
            end
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_code   = 4'h0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_code  = alu_dec;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_code  = alu_dec;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_code  = 4'h1;
                pc_write  = taken && br_legal;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            S_JALWB: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_LUI: begin
                alu_src_b = 2'b01;
                alu_code  = 4'hA;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
`ifdef MULDIV_EN
            S_MULDIV: begin
                if (md_done) begin
                    result_src = 2'b11;
                    reg_write  = 1'b1;
                end
            end
`endif
            default: ;
        endcase
        // Reset must kill an in-flight request immediately, not at the next edge.
        if (rst) begin
            mem_req   = 1'b0;
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction sequences, branches, handshake waits, timeout and traps.
module tb_multicycle_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b1;

    logic       mem_req, pc_write, adr_src, ir_write, mem_write, reg_write, trap;
    logic [1:0] result_src, alu_src_a, alu_src_b, trap_cause;
    logic [2:0] imm_src;
    logic [3:0] alu_control;

    logic       z_mem_req, z_pc_write, z_adr_src, z_ir_write, z_mem_write, z_reg_write, z_trap;
    logic [1:0] z_result_src, z_alu_src_a, z_alu_src_b, z_trap_cause;
    logic [2:0] z_imm_src;
    logic [3:0] z_alu_control;

    multicycle_controller #(.ALU_CTRL_W(4), .IMM_SRC_W(3), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .trap(trap), .trap_cause(trap_cause)
    );

    multicycle_controller #(.ALU_CTRL_W(4), .IMM_SRC_W(3), .MEM_TIMEOUT(0)) dut_nt (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(z_mem_req), .pc_write(z_pc_write), .adr_src(z_adr_src), .ir_write(z_ir_write),
        .mem_write(z_mem_write), .reg_write(z_reg_write), .result_src(z_result_src),
        .alu_src_a(z_alu_src_a), .alu_src_b(z_alu_src_b), .imm_src(z_imm_src),
        .alu_control(z_alu_control), .trap(z_trap), .trap_cause(z_trap_cause)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_fields(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        op     = o;
        funct3 = f3;
        funct7 = f7;
    endtask

    // Leaves the bench just after reset release, in the first FETCH cycle.
    task automatic do_reset;
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Runs FETCH -> DECODE -> EXEC -> ALUWB -> FETCH for an ALU op and checks the ALU code.
    task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [3:0] exp_alu);
        set_fields(o, f3, f7);
        tick;
        tick;
        check({tag, "_alu"}, alu_control, exp_alu);
        check({tag, "_srca"}, alu_src_a, 2'b10);
        tick;
        check({tag, "_wb"}, reg_write, 1'b1);
        tick;
    endtask

    task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                              input logic l, input logic lu, input logic exp_pcw);
        set_fields(7'b1100011, f3, 7'b0);
        zero = z;
        lt   = l;
        ltu  = lu;
        tick;
        tick;
        check({tag, "_pcw"}, pc_write, exp_pcw);
        check({tag, "_alu"}, alu_control, 4'h1);
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        set_fields(7'b0110011, 3'b000, 7'b0000000);
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_ir_write", ir_write, 1'b0);
        check("rst_pc_write", pc_write, 1'b0);
        check("rst_trap", trap, 1'b0);
        check("rst_cause", trap_cause, 2'b00);
        rst = 1'b0;
        #1;

        // ADD x3,x1,x2
        check("add_f_req", mem_req, 1'b1);
        check("add_f_irw", ir_write, 1'b1);
        check("add_f_srcb", alu_src_b, 2'b10);
        tick;
        check("add_d_srca", alu_src_a, 2'b01);
        check("add_d_req", mem_req, 1'b0);
        tick;
        check("add_e_srcb", alu_src_b, 2'b00);
        check("add_e_alu", alu_control, 4'h0);
        check("add_e_rw", reg_write, 1'b0);
        tick;
        check("add_wb_rw", reg_write, 1'b1);
        check("add_wb_res", result_src, 2'b00);
        tick;
        check("add_next_f", mem_req, 1'b1);

        run_alu("sub", 7'b0110011, 3'b000, 7'b0100000, 4'h1);
        run_alu("addi_neg", 7'b0010011, 3'b000, 7'b1111111, 4'h0);
        run_alu("srai", 7'b0010011, 3'b101, 7'b0100000, 4'h9);
        run_alu("srl", 7'b0110011, 3'b101, 7'b0000000, 4'h8);
        run_alu("sltu", 7'b0110011, 3'b011, 7'b0000000, 4'h6);

        // LW with three wait cycles
        set_fields(7'b0000011, 3'b010, 7'b0);
        tick;
        tick;
        check("lw_ma_srca", alu_src_a, 2'b10);
        check("lw_ma_srcb", alu_src_b, 2'b01);
        mem_ready = 1'b0;
        tick;
        for (int i = 1; i <= 4; i++) begin
            check("lw_rd_req", mem_req, 1'b1);
            check("lw_rd_adr", adr_src, 1'b1);
            check("lw_rd_rw", reg_write, 1'b0);
            if (i == 4) mem_ready = 1'b1;
            tick;
        end
        check("lw_wb_rw", reg_write, 1'b1);
        check("lw_wb_res", result_src, 2'b01);
        check("lw_wb_req", mem_req, 1'b0);
        tick;

        // SW
        set_fields(7'b0100011, 3'b010, 7'b0);
        tick;
        tick;
        check("sw_imm", imm_src, 3'b001);
        tick;
        check("sw_mw", mem_write, 1'b1);
        check("sw_req", mem_req, 1'b1);
        tick;
        check("sw_back_mw", mem_write, 1'b0);
        check("sw_back_srcb", alu_src_b, 2'b10);

        run_branch("blt_t", 3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
        run_branch("blt_n", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        run_branch("bgeu_t", 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        run_branch("bgeu_n", 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
        run_branch("beq_t", 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        run_branch("bne_n", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        run_branch("bge_t", 3'b101, 1'b0, 1'b0, 1'b1, 1'b1);
        run_branch("bltu_t", 3'b110, 1'b0, 1'b0, 1'b1, 1'b1);

        // JAL
        set_fields(7'b1101111, 3'b000, 7'b0);
        tick;
        tick;
        check("jal_pcw", pc_write, 1'b1);
        check("jal_srca", alu_src_a, 2'b01);
        check("jal_srcb", alu_src_b, 2'b10);
        check("jal_imm", imm_src, 3'b011);
        tick;
        check("jal_wb", reg_write, 1'b1);
        tick;

        // JALR
        set_fields(7'b1100111, 3'b000, 7'b0);
        tick;
        tick;
        check("jalr_pcw", pc_write, 1'b1);
        check("jalr_res", result_src, 2'b10);
        tick;
        check("jalwb_pcw", pc_write, 1'b0);
        check("jalwb_srca", alu_src_a, 2'b01);
        tick;
        check("jalr_wb", reg_write, 1'b1);
        tick;

        // LUI
        set_fields(7'b0110111, 3'b000, 7'b0);
        tick;
        tick;
        check("lui_alu", alu_control, 4'hA);
        check("lui_imm", imm_src, 3'b100);
        tick;
        check("lui_wb", reg_write, 1'b1);
        tick;

        // Branch with reserved funct3 traps as illegal
        run_branch("br_010", 3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
        check("br_010_trap", trap, 1'b1);
        check("br_010_cause", trap_cause, 2'b01);
        tick;
        check("trap_hold_req", mem_req, 1'b0);
        check("trap_hold", trap, 1'b1);
        rst = 1'b1;
        #1;
        check("trap_async_clr", trap, 1'b0);
        tick;
        rst = 1'b0;
        #1;

        // op=0000000 illegal
        set_fields(7'b0000000, 3'b000, 7'b0);
        tick;
        tick;
        check("ill_trap", trap, 1'b1);
        check("ill_cause", trap_cause, 2'b01);

        // MUL without the muldiv option traps as illegal
        do_reset;
        check("rst2_trap", trap, 1'b0);
        set_fields(7'b0110011, 3'b000, 7'b0000001);
        tick;
        tick;
        check("mul_trap", trap, 1'b1);
        check("mul_cause", trap_cause, 2'b01);

        // Fetch timeout after eight unanswered cycles
        do_reset;
        mem_ready = 1'b0;
        repeat (7) tick;
        check("to_c8_req", mem_req, 1'b1);
        check("to_c8_trap", trap, 1'b0);
        tick;
        check("to_trap", trap, 1'b1);
        check("to_cause", trap_cause, 2'b10);
        check("to_req", mem_req, 1'b0);
        repeat (4) tick;
        check("nt_trap", z_trap, 1'b0);
        check("nt_req", z_mem_req, 1'b1);
        rst = 1'b1;
        #1;
        check("nt_async_req", z_mem_req, 1'b0);

        // Ready on the limit cycle wins over the timeout
        do_reset;
        mem_ready = 1'b0;
        repeat (7) tick;
        mem_ready = 1'b1;
        #1;
        check("win_irw", ir_write, 1'b1);
        tick;
        check("win_trap", trap, 1'b0);
        check("win_decode", alu_src_a, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
